// File: rtl/aes_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_pkg
// Purpose  : Shared constants for the pipelined AES S-box: lane byte width,
//            the AES affine constant, the forward and inverse substitution
//            tables, and a parameter range check used by the top level.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_sbox_pkg;

    localparam int          BYTE_W   = 8;
    // Affine constant of the S-box transform; also the value S(0x00).
    localparam logic [7:0]  AFFINE_C = 8'h63;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Legal build configurations of aes_sbox_pipe.
    function automatic bit params_ok(input int lanes, input int stages,
                                     input int masked, input int tag_w);
        return (lanes  >= 1) && (lanes  <= 16) &&
               (stages >= 1) && (stages <= 4)  &&
               ((masked == 0) || (masked == 1)) &&
               (tag_w  >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_lane.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_lane
// Purpose  : Single-byte AES substitution, forward or inverse. Purely
//            combinational table lookup.
// Ports    : i_byte  - byte to substitute
//            i_inv   - 0 = SubBytes, 1 = InvSubBytes
//            o_byte  - substituted byte
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_inv,
    output logic [BYTE_W-1:0] o_byte
);

    always_comb begin
        o_byte = i_inv ? INV_SBOX[i_byte] : SBOX[i_byte];
    end

endmodule
`default_nettype wire

// File: rtl/aes_sbox_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_pipe
// Purpose  : Multi-lane AES S-box with optional first-order Boolean masking
//            and a STAGES-deep valid/ready elastic pipeline.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - input handshake
//            in_inv              - 0 = forward, 1 = inverse substitution
//            in_data             - LANES input bytes, lane i at [8i+7:8i]
//            in_mask, out_mask   - per-lane masks (only when MASKED=1)
//            in_tag              - sideband tag carried with the data
//            out_valid/out_ready - output handshake
//            out_data, out_tag   - substituted bytes and their tag
//            busy                - any stage holds a valid transaction
//            xfer_count          - wrapping count of output handshakes
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_pipe
    import aes_sbox_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int MASKED = 0,
    parameter int TAG_W  = 4
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_inv,
    input  logic [BYTE_W*LANES-1:0]   in_data,
    input  logic [BYTE_W*LANES-1:0]   in_mask,
    input  logic [BYTE_W*LANES-1:0]   out_mask,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      busy,
    output logic [15:0]               xfer_count
);

    localparam int DATA_W = BYTE_W * LANES;

    if (!params_ok(LANES, STAGES, MASKED, TAG_W)) begin : g_param_error
        $error("aes_sbox_pipe: parameter out of range");
    end

    logic                 w_en;
    logic [DATA_W-1:0]    w_unmasked;
    logic [DATA_W-1:0]    w_subst;
    logic [DATA_W-1:0]    w_result;

    logic [STAGES-1:0]    valid_q, valid_d;
    logic [DATA_W-1:0]    data_q [STAGES];
    logic [DATA_W-1:0]    data_d [STAGES];
    logic [TAG_W-1:0]     tag_q  [STAGES];
    logic [TAG_W-1:0]     tag_d  [STAGES];
    logic [15:0]          xfer_count_q, xfer_count_d;

    // The whole substitution happens ahead of stage 0, so every stage just
    // carries the finished result; mode, masks and tag are consumed in the
    // same cycle as the data and never looked at again.
    assign w_unmasked = in_data ^ ((MASKED != 0) ? in_mask : '0);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_lane u_lane (
            .i_byte (w_unmasked[l*BYTE_W +: BYTE_W]),
            .i_inv  (in_inv),
            .o_byte (w_subst[l*BYTE_W +: BYTE_W])
        );
    end

    assign w_result = w_subst ^ ((MASKED != 0) ? out_mask : '0);

    // Single global advance: the whole pipe moves whenever the output slot
    // is empty or being drained, otherwise everything freezes.
    assign w_en     = !valid_q[STAGES-1] || out_ready;
    assign in_ready = w_en;

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        tag_d        = tag_q;
        xfer_count_d = xfer_count_q;

        if (w_en) begin
            valid_d[0] = in_valid;
            // Payload registers only toggle when a real transaction enters
            // them, so bubbles do not cause data-dependent transitions.
            if (in_valid) begin
                data_d[0] = w_result;
                tag_d[0]  = in_tag;
            end
            for (int s = 1; s < STAGES; s++) begin
                valid_d[s] = valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_d[s] = data_q[s-1];
                    tag_d[s]  = tag_q[s-1];
                end
            end
        end

        if (valid_q[STAGES-1] && out_ready) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            xfer_count_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_data   = data_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];
    assign busy       = |valid_q;
    assign xfer_count = xfer_count_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sbox_pipe
// Purpose  : Self-checking bench for aes_sbox_pipe. A masked 4-lane 3-stage
//            instance and an unmasked 1-lane 1-stage instance share stimulus;
//            both are scored against S-box tables rebuilt from GF(2^8)
//            arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_pipe;

    localparam int LANES  = 4;
    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [31:0] in_data, in_mask, out_mask, out_data;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] xfer_count;

    logic        u_in_ready, u_out_valid, u_busy;
    logic [7:0]  u_out_data;
    logic [3:0]  u_out_tag;
    logic [15:0] u_xfer_count;

    aes_sbox_pipe #(.LANES(LANES), .STAGES(STAGES), .MASKED(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inv(in_inv), .in_data(in_data), .in_mask(in_mask), .out_mask(out_mask),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy), .xfer_count(xfer_count)
    );

    aes_sbox_pipe #(.LANES(1), .STAGES(1), .MASKED(0), .TAG_W(4)) u_unmasked (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_inv(in_inv), .in_data(in_data[7:0]), .in_mask(in_mask[7:0]),
        .out_mask(out_mask[7:0]), .in_tag(in_tag), .out_valid(u_out_valid),
        .out_ready(out_ready), .out_data(u_out_data), .out_tag(u_out_tag),
        .busy(u_busy), .xfer_count(u_xfer_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ref_s   [256];
    logic [7:0]  ref_inv [256];
    logic [35:0] q_m [$];
    logic [11:0] q_u [$];
    logic [15:0] xm_exp = '0, xu_exp = '0;
    logic        hold_v = 1'b0, u_hold_v = 1'b0;
    logic [35:0] hold_val;
    logic [11:0] u_hold_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        if (a == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] w = {b, b};
        return w[15-k -: 8];
    endfunction

    function automatic logic [31:0] model_m(input logic [31:0] d, input logic [31:0] im,
                                            input logic [31:0] om, input logic inv);
        logic [31:0] r;
        logic [7:0]  x;
        for (int l = 0; l < 4; l++) begin
            x = d[8*l +: 8] ^ im[8*l +: 8];
            r[8*l +: 8] = (inv ? ref_inv[x] : ref_s[x]) ^ om[8*l +: 8];
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] im,
                         input logic [31:0] om, input logic inv, input logic [3:0] t,
                         input logic ordy);
        in_valid = v; in_data = d; in_mask = im; out_mask = om;
        in_inv = inv; in_tag = t; out_ready = ordy;
    endtask

    task automatic drive_rand(input logic v, input logic ordy);
        drive(v, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), ordy);
    endtask

    // One clock cycle: score handshakes that will happen at the coming edge,
    // then advance and check counters/busy against the model.
    task automatic step(output logic acc);
        logic        hs_out, u_acc, u_hs_out;
        logic [35:0] e;
        logic [11:0] eu;
        #1;
        chk("in_ready", in_ready, !out_valid || out_ready);
        chk("u_in_ready", u_in_ready, !u_out_valid || out_ready);
        if (hold_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_payload", {out_tag, out_data}, hold_val);
        end
        if (u_hold_v) begin
            chk("u_hold_valid", u_out_valid, 1);
            chk("u_hold_payload", {u_out_tag, u_out_data}, u_hold_val);
        end
        acc      = in_valid && in_ready;
        u_acc    = in_valid && u_in_ready;
        hs_out   = out_valid && out_ready;
        u_hs_out = u_out_valid && out_ready;
        if (hs_out) begin
            if (q_m.size() == 0) chk("out_unexpected", out_valid, 0);
            else begin
                e = q_m.pop_front();
                chk("out_data", out_data, e[31:0]);
                chk("out_tag", out_tag, e[35:32]);
            end
        end
        if (u_hs_out) begin
            if (q_u.size() == 0) chk("u_out_unexpected", u_out_valid, 0);
            else begin
                eu = q_u.pop_front();
                chk("u_out_data", u_out_data, eu[7:0]);
                chk("u_out_tag", u_out_tag, eu[11:8]);
            end
        end
        if (acc)   q_m.push_back({in_tag, model_m(in_data, in_mask, out_mask, in_inv)});
        if (u_acc) q_u.push_back({in_tag, in_inv ? ref_inv[in_data[7:0]] : ref_s[in_data[7:0]]});
        hold_v     = out_valid && !out_ready;
        hold_val   = {out_tag, out_data};
        u_hold_v   = u_out_valid && !out_ready;
        u_hold_val = {u_out_tag, u_out_data};
        @(posedge clk);
        if (hs_out)   xm_exp = xm_exp + 16'd1;
        if (u_hs_out) xu_exp = xu_exp + 16'd1;
        @(negedge clk);
        chk("xfer_count", xfer_count, xm_exp);
        chk("busy", busy, q_m.size() != 0);
        chk("u_xfer_count", u_xfer_count, xu_exp);
        chk("u_busy", u_busy, q_u.size() != 0);
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        drive(0, 0, 0, 0, 0, 0, 1);
        while ((q_m.size() != 0 || q_u.size() != 0) && n < 100) begin
            step(acc);
            n++;
        end
        chk("drain_timeout", q_m.size() + q_u.size(), 0);
    endtask

    task automatic directed(input string name, input logic [31:0] d, input logic [31:0] im,
                            input logic [31:0] om, input logic inv, input logic [3:0] t,
                            input logic [31:0] exp, input logic [7:0] u_exp);
        logic acc;
        int   lat;
        drive(1, d, im, om, inv, t, 1);
        step(acc);
        chk({name, "_accept"}, acc, 1);
        chk({name, "_unmasked_data"}, u_out_data, u_exp);
        drive(0, 0, 0, 0, 0, 0, 1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step(acc);
            lat++;
        end
        chk({name, "_latency"}, lat, STAGES);
        chk({name, "_data"}, out_data, exp);
        chk({name, "_tag"}, out_tag, t);
        step(acc);
    endtask

    initial begin
        logic        acc;
        logic [7:0]  b, s;
        logic [31:0] d;
        logic [15:0] base;
        int          guard;

        for (int a = 0; a < 256; a++) begin
            b = ginv(8'(a));
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            ref_s[a]   = s;
            ref_inv[s] = 8'(a);
        end

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xfer", xfer_count, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_u_out_valid", u_out_valid, 0);
        chk("rst_u_out_data", u_out_data, 0);
        rst = 1'b0;

        // Known-answer transactions
        directed("fwd", 32'h5301_0053, 0, 0, 0, 4'h3, 32'hED7C_63ED, 8'hED);
        chk("fwd_xfer", xfer_count, 1);
        directed("inv", 32'h0000_ED63, 0, 0, 1, 4'h5, 32'h5252_5300, 8'h00);
        directed("masked", 32'h0000_00F6, 32'h0000_00A5, 32'h0000_003C, 0, 4'hA,
                 32'h6363_63D1, 8'h42);

        // All 256 bytes in both modes, random masks, stalls and bubbles
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 64; k++) begin
                d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                if ($urandom_range(0, 3) == 0) begin
                    drive_rand(0, 1'($urandom_range(0, 1)));
                    step(acc);
                end
                acc = 1'b0;
                guard = 0;
                while (!acc && guard < 50) begin
                    drive(1, d, $urandom, $urandom, 1'(m), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3) != 0);
                    step(acc);
                    guard++;
                end
                chk("exh_accept_timeout", acc, 1);
            end
        end
        drain();

        // Fully random traffic
        for (int i = 0; i < 400; i++) begin
            drive_rand($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            step(acc);
        end
        drain();

        // Back-pressure: 16 bytes streamed, output stalled 4 cycles mid-stream
        base = xm_exp;
        for (int bb = 0; bb < 16; bb++) begin
            if (bb == 6) begin
                for (int c = 0; c < 4; c++) begin
                    drive(1, {4{8'(bb)}}, 0, 0, 0, 4'(bb), 0);
                    #1;
                    chk("stall_in_ready", in_ready, 0);
                    step(acc);
                end
            end
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 20) begin
                drive(1, {4{8'(bb)}}, 0, 0, 0, 4'(bb), 1);
                step(acc);
                guard++;
            end
            chk("bp_accept_timeout", acc, 1);
        end
        drain();
        chk("bp_xfer", xfer_count - base, 16);

        // Reset with two transactions in flight
        for (int i = 0; i < 2; i++) begin
            drive_rand(1, 1);
            step(acc);
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_xfer", xfer_count, 0);
        chk("midrst_u_out_valid", u_out_valid, 0);
        q_m.delete(); q_u.delete();
        xm_exp = '0; xu_exp = '0;
        hold_v = 1'b0; u_hold_v = 1'b0;
        for (int i = 0; i < 6; i++) step(acc);

        // 65536 back-to-back transfers: counter wraps to zero
        for (int i = 0; i < 65536; i++) begin
            drive_rand(1, 1);
            step(acc);
            if (!acc) chk("wrap_accept", acc, 1);
        end
        drain();
        chk("wrap_xfer", xfer_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
